// File: rtl/maze_path_playback_if.sv
// -----------------------------------------------------------------------------
// maze_path_playback_if
//   Bundles the two buses owned by the playback sequencer:
//     - the solver position-stack read port (rd enable, address, read data)
//     - the coordinate output stream (x, y, last) with valid/ready handshake
//
//   Signals
//     stk_rd     playback -> stack   read enable, one cycle per entry
//     stk_raddr  playback -> stack   read address (entry index)
//     stk_rdata  stack -> playback   {x, y}, valid the cycle after stk_rd
//     out_x      playback -> sink    presented x coordinate
//     out_y      playback -> sink    presented y coordinate
//     out_valid  playback -> sink    coordinate valid
//     out_last   playback -> sink    final coordinate of the path
//     out_ready  sink -> playback    sink accepts the coordinate
//
//   Modports
//     master  the playback sequencer
//     slave   the stack memory plus the coordinate consumer
// -----------------------------------------------------------------------------
interface maze_path_playback_if #(
  parameter int COORD_W = 4,
  parameter int ADDR_W  = 8
);

  logic                   stk_rd;
  logic [ADDR_W-1:0]      stk_raddr;
  logic [2*COORD_W-1:0]   stk_rdata;

  logic [COORD_W-1:0]     out_x;
  logic [COORD_W-1:0]     out_y;
  logic                   out_valid;
  logic                   out_last;
  logic                   out_ready;

  modport master (
    output stk_rd,
    output stk_raddr,
    input  stk_rdata,
    output out_x,
    output out_y,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  stk_rd,
    input  stk_raddr,
    output stk_rdata,
    input  out_x,
    input  out_y,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/maze_path_playback.sv
// -----------------------------------------------------------------------------
// maze_path_playback
//   Replays the maze solver's position stack once the search has finished.
//   Entries are read from the bottom of the stack (first visited cell) up to
//   the top (goal cell) and presented one at a time as (x, y) coordinates on a
//   valid/ready stream. The stack read port is only driven while busy; in
//   IDLE stk_rd stays low so the solver datapath owns the memory.
//
//   Ports
//     clk            clock, rising edge
//     rst            synchronous, active-high reset
//     i_start        one-cycle playback request, honoured only in IDLE
//     i_abort        cancel playback, back to IDLE on the next edge
//     i_stack_count  number of valid stack entries, sampled on start
//     bus            stack read port + coordinate stream (master side)
//     o_busy         high in every state except IDLE
//     o_done         one-cycle pulse at the end of playback
//     o_empty_err    qualifies o_done when the sampled count was zero
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   S_IDLE    | stack port released, waiting for i_start
//   S_CHECK   | decide between empty playback and first fetch
//   S_FETCH   | stk_rd=1, stk_raddr=idx for one cycle
//   S_WAIT    | stk_rdata valid, capture x/y/last into output registers
//   S_PRESENT | out_valid=1, hold coordinate until out_ready
//   S_FINISH  | o_done pulse (o_empty_err when count was zero)
// -----------------------------------------------------------------------------
module maze_path_playback #(
  parameter int COORD_W = 4,
  parameter int ADDR_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [ADDR_W:0]        i_stack_count,
  maze_path_playback_if.master   bus,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_empty_err
);

  // Full stack: 2^ADDR_W entries, needs the extra count bit.
  localparam logic [ADDR_W:0] C_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] C_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] C_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_FETCH   = 3'd2,
    S_WAIT    = 3'd3,
    S_PRESENT = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic [ADDR_W:0]      r_cnt;
  logic [ADDR_W:0]      r_idx;
  logic                 r_empty;
  logic [COORD_W-1:0]   r_x;
  logic [COORD_W-1:0]   r_y;
  logic                 r_last;

  logic [ADDR_W:0]      w_cnt_clamped;
  logic                 w_accept;
  logic                 w_advance;
  logic                 w_is_last;
  logic                 w_cancel;

  // Counts above the stack depth cannot be real; clamp so idx never wraps.
  assign w_cnt_clamped = (i_stack_count > C_FULL) ? C_FULL : i_stack_count;

  // Full-width compare so a 2^ADDR_W count terminates at idx 2^ADDR_W-1.
  assign w_is_last = (r_idx == (r_cnt - C_ONE));

  // abort only matters outside IDLE; in IDLE a start is still accepted.
  assign w_cancel = i_abort && (r_state != S_IDLE);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_advance = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept = 1'b1;
          w_next   = S_CHECK;
        end
      end

      S_CHECK: begin
        if (r_cnt == C_ZERO) begin
          w_next = S_FINISH;
        end else begin
          w_next = S_FETCH;
        end
      end

      S_FETCH: begin
        w_next = S_WAIT;
      end

      S_WAIT: begin
        w_next = S_PRESENT;
      end

      S_PRESENT: begin
        if (bus.out_ready) begin
          if (r_last) begin
            w_next = S_FINISH;
          end else begin
            w_advance = 1'b1;
            w_next    = S_FETCH;
          end
        end
      end

      S_FINISH: begin
        w_next = S_IDLE;
      end

      default: begin
        w_next = S_IDLE;
      end
    endcase

    // Abort overrides everything, including a coinciding handshake: the
    // coordinate then counts as not delivered and idx must not move.
    if (w_cancel) begin
      w_next    = S_IDLE;
      w_advance = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: latched count, entry index, captured coordinate
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_empty <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= w_cnt_clamped;
        r_idx   <= '0;
        r_empty <= 1'b0;
      end

      if (r_state == S_CHECK) begin
        r_empty <= (r_cnt == C_ZERO);
      end

      if (r_state == S_WAIT) begin
        r_x    <= bus.stk_rdata[2*COORD_W-1:COORD_W];
        r_y    <= bus.stk_rdata[COORD_W-1:0];
        r_last <= w_is_last;
      end

      if (w_advance) begin
        r_idx <= r_idx + C_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from the registered state
  // ---------------------------------------------------------------------------
  assign bus.stk_rd    = (r_state == S_FETCH);
  assign bus.stk_raddr = r_idx[ADDR_W-1:0];

  assign bus.out_x     = r_x;
  assign bus.out_y     = r_y;
  assign bus.out_last  = r_last;
  assign bus.out_valid = (r_state == S_PRESENT);

  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = (r_state == S_FINISH);
  assign o_empty_err   = (r_state == S_FINISH) && r_empty;

endmodule

// File: tb/tb_maze_path_playback.sv
module tb_maze_path_playback;

  localparam int COORD_W = 4;
  localparam int ADDR_W  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [8:0] stack_count = '0;
  logic       busy;
  logic       done;
  logic       empty_err;

  always #5 clk = ~clk;

  maze_path_playback_if #(.COORD_W(COORD_W), .ADDR_W(ADDR_W)) bus ();

  maze_path_playback #(.COORD_W(COORD_W), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (start),
    .i_abort       (abort),
    .i_stack_count (stack_count),
    .bus           (bus.master),
    .o_busy        (busy),
    .o_done        (done),
    .o_empty_err   (empty_err)
  );

  // Stack memory model: synchronous read, data valid the cycle after stk_rd.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (bus.stk_rd) bus.stk_rdata <= mem[bus.stk_raddr];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Scoreboard entries: {x, y, last}
  logic [8:0] sb[$];
  int hs_cyc[$];
  int hs_cnt = 0, done_cnt = 0, rd_cnt = 0, busy_cnt = 0, valid_cnt = 0;
  int done_cyc = 0;
  logic done_empty = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at the falling edge (inputs stable), then advance.
  task automatic tick();
    logic [8:0] e;
    @(negedge clk);
    if (bus.out_valid && bus.out_ready && !abort && !rst) begin
      hs_cnt++;
      hs_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("sb_underflow", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check("coord", {bus.out_x, bus.out_y, bus.out_last}, e);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_empty = empty_err;
    end
    if (bus.stk_rd) rd_cnt++;
    if (busy) busy_cnt++;
    if (bus.out_valid) valid_cnt++;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run_to_done(input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", done_cnt - d0, 1);
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!bus.out_valid && n < budget) begin
      tick();
      n++;
    end
    check("valid_reached", bus.out_valid, 1);
  endtask

  task automatic push_range(input int n);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      v = mem[i];
      sb.push_back({v, (i == n - 1) ? 1'b1 : 1'b0});
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int t, b0, r0, v0, h0, d0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_valid", bus.out_valid, 0);
    check("rst_stk_rd", bus.stk_rd, 0);
    check("rst_raddr", bus.stk_raddr, 0);
    check("rst_xy_last", {bus.out_x, bus.out_y, bus.out_last}, 0);
    check("rst_busy_done_err", {busy, done, empty_err}, 0);
    rst = 1'b0;
    tick();

    // Three entries, latency and last flag
    mem[0] = 8'h12; mem[1] = 8'h13; mem[2] = 8'h23;
    stack_count = 9'd3;
    push_range(3);
    hs_cyc.delete();
    b0 = busy_cnt;
    pulse_start();
    t = cyc - 1;
    run_to_done(40);
    for (int k = 0; k < 3; k++) begin
      if (k < hs_cyc.size()) check("t1_hs_cycle", hs_cyc[k], t + 4 + 3 * k);
      else check("t1_hs_missing", hs_cyc.size(), 3);
    end
    check("t1_done_cycle", done_cyc, t + 11);
    check("t1_empty_err", done_empty, 0);
    check("t1_busy_cycles", busy_cnt - b0, 11);
    check("t1_busy_low", busy, 0);
    check("t1_sb_drained", sb.size(), 0);

    // Empty stack
    stack_count = 9'd0;
    b0 = busy_cnt; r0 = rd_cnt; v0 = valid_cnt;
    pulse_start();
    t = cyc - 1;
    run_to_done(10);
    check("t2_done_cycle", done_cyc, t + 2);
    check("t2_empty_err", done_empty, 1);
    check("t2_no_rd", rd_cnt - r0, 0);
    check("t2_no_valid", valid_cnt - v0, 0);
    check("t2_busy_cycles", busy_cnt - b0, 2);

    // Backpressure on the first coordinate
    mem[0] = 8'hA5; mem[1] = 8'h5A;
    stack_count = 9'd2;
    push_range(2);
    bus.out_ready = 1'b0;
    r0 = rd_cnt;
    pulse_start();
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", bus.out_valid, 1);
      check("bp_xy_last", {bus.out_x, bus.out_y, bus.out_last}, 9'h14A);
      check("bp_single_rd", rd_cnt - r0, 1);
    end
    bus.out_ready = 1'b1;
    run_to_done(20);
    check("bp_total_rd", rd_cnt - r0, 2);
    check("bp_sb_drained", sb.size(), 0);

    // Full stack, address order and 770 busy cycles
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    stack_count = 9'd256;
    push_range(256);
    b0 = busy_cnt; r0 = rd_cnt; h0 = hs_cnt; d0 = done_cnt;
    pulse_start();
    run_to_done(1000);
    check("full_busy_cycles", busy_cnt - b0, 770);
    check("full_rd", rd_cnt - r0, 256);
    check("full_hs", hs_cnt - h0, 256);
    check("full_sb_drained", sb.size(), 0);
    tick();
    check("full_one_done", done_cnt - d0, 1);

    // Count above depth is clamped
    stack_count = 9'h1FF;
    push_range(256);
    b0 = busy_cnt; h0 = hs_cnt;
    pulse_start();
    run_to_done(1000);
    check("clamp_busy_cycles", busy_cnt - b0, 770);
    check("clamp_hs", hs_cnt - h0, 256);
    check("clamp_sb_drained", sb.size(), 0);

    // Abort in the second PRESENT, coinciding with ready and start
    stack_count = 9'd4;
    push_range(4);
    h0 = hs_cnt; d0 = done_cnt;
    pulse_start();
    while (hs_cnt - h0 < 1 && cyc < 100000) tick();
    wait_valid(10);
    check("ab_second_x_y", {bus.out_x, bus.out_y}, 8'h01);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("ab_valid_low", bus.out_valid, 0);
    check("ab_rd_low", bus.stk_rd, 0);
    check("ab_idle", busy, 0);
    tick();
    check("ab_start_ignored", busy, 0);
    check("ab_no_done", done_cnt - d0, 0);
    check("ab_delivered", hs_cnt - h0, 1);
    sb.delete();
    push_range(4);
    h0 = hs_cnt;
    pulse_start();
    run_to_done(40);
    check("ab_replay_hs", hs_cnt - h0, 4);
    check("ab_replay_sb", sb.size(), 0);

    // Same run with reset in the second PRESENT
    push_range(4);
    h0 = hs_cnt;
    pulse_start();
    while (hs_cnt - h0 < 1 && cyc < 100000) tick();
    wait_valid(10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rr_valid_rd", {bus.out_valid, bus.stk_rd}, 0);
    check("rr_raddr", bus.stk_raddr, 0);
    check("rr_xy_last", {bus.out_x, bus.out_y, bus.out_last}, 0);
    check("rr_busy_done_err", {busy, done, empty_err}, 0);
    sb.delete();
    tick();

    // Re-pulsed start and changed count during a run
    stack_count = 9'd3;
    push_range(3);
    b0 = busy_cnt; h0 = hs_cnt;
    pulse_start();
    stack_count = 9'd5;
    wait_valid(10);
    pulse_start();
    run_to_done(40);
    check("rs_busy_cycles", busy_cnt - b0, 11);
    check("rs_hs", hs_cnt - h0, 3);
    check("rs_sb_drained", sb.size(), 0);

    // Abort alone in IDLE
    d0 = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    check("idle_abort_busy", busy, 0);
    check("idle_abort_done", done_cnt - d0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maze_path_playback.md
Name: maze_path_playback

Overview:
- Sequences readout of the solver's position stack after the maze search reports Done.
- Reads stack entries from bottom (first cell visited) to top (goal cell).
- Presents each cell as an (x, y) coordinate on a valid/ready output stream, for a display or UART formatter.
- Owns the stack read port only while busy. Otherwise leaves it idle so the solver datapath has exclusive use of it.

Parameters:
- COORD_W, 4, width of one coordinate; the maze is 2^COORD_W x 2^COORD_W.
- ADDR_W, 8, stack address width; stack depth is 2^ADDR_W entries.

Ports:
- clk  input  1  clock; all logic is sampled on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle request to begin playback; honoured only in IDLE.
- abort  input  1  cancels playback and returns to IDLE on the next edge.
- stack_count  input  ADDR_W+1  number of valid stack entries; sampled when start is accepted.
- stk_rd  output  1  stack read enable.
- stk_raddr  output  ADDR_W  stack read address.
- stk_rdata  input  2*COORD_W  read data, valid in the cycle after stk_rd; {x, y} with x in the upper half.
- out_x  output  COORD_W  presented x coordinate.
- out_y  output  COORD_W  presented y coordinate.
- out_valid  output  1  coordinate valid.
- out_ready  input  1  consumer accepts the coordinate.
- out_last  output  1  qualifies the final coordinate; meaningful only while out_valid=1.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when playback completes or is found empty.
- empty_err  output  1  high together with done when the latched count was 0.

Behaviour:
- Reset values: all outputs are 0, state is IDLE, index is 0, latched count is 0.
- rst applies at any time, including mid-playback. It is checked before abort.
- States: IDLE, CHECK, FETCH, WAIT, PRESENT, FINISH.
- IDLE:
  - If start=1: latch cnt = min(stack_count, 2^ADDR_W), set idx = 0, go to CHECK.
  - If start=0: stay in IDLE.
- CHECK:
  - If cnt == 0: go to FINISH with the empty flag set.
  - Otherwise: go to FETCH.
- FETCH: drive stk_rd=1 and stk_raddr=idx for this one cycle, then go to WAIT.
- WAIT:
  - stk_rdata is valid in this cycle.
  - Register out_x = stk_rdata[2*COORD_W-1:COORD_W] and out_y = stk_rdata[COORD_W-1:0].
  - Register out_last = (idx == cnt-1).
  - Go to PRESENT.
- PRESENT:
  - Hold out_valid=1 with out_x, out_y and out_last stable until out_ready=1 at an edge.
  - On that handshake with out_last=1: go to FINISH.
  - On that handshake with out_last=0: increment idx and go to FETCH.
  - out_valid deasserts in the cycle after the handshake.
- FINISH: done=1 for exactly one cycle, empty_err = empty flag, then go to IDLE.
- Latency:
  - start accepted at edge t puts state CHECK in cycle t+1.
  - First stk_rd occurs in cycle t+2 and the first out_valid in cycle t+4.
  - With out_ready held at 1, each coordinate takes 3 cycles (FETCH, WAIT, PRESENT).
  - Total busy cycles for N entries is 2 + 3N (CHECK, the N coordinate slots, FINISH).
- start in any state other than IDLE is ignored. It is not queued.
- Changes to stack_count after start is accepted have no effect until the next playback.
- Full stack (stack_count >= 2^ADDR_W):
  - cnt is clamped to 2^ADDR_W.
  - idx counts to 2^ADDR_W-1 and never wraps; the comparison uses ADDR_W+1 bits.
- abort=1 in any non-IDLE state:
  - The next state is IDLE, and out_valid and stk_rd drop on that edge.
  - No done pulse is generated.
  - If start=1 in the same cycle as abort, start is ignored.
- abort in IDLE has no effect.
- If abort and the out_ready handshake coincide in PRESENT, abort wins and the coordinate counts as not delivered.
- stk_rd is 0 in every state except FETCH. stk_raddr holds idx in all states.

Test Plan:
- Entries {1,2}, {1,3}, {2,3} with count=3, start pulse, out_ready=1:
  - Coordinates (1,2), (1,3), (2,3) appear in cycles t+4, t+7 and t+10.
  - out_last=1 only on (2,3).
  - done is high in cycle t+11 and busy falls in cycle t+12.
- count=0, then start:
  - No stk_rd and no out_valid.
  - done=1 and empty_err=1 in cycle t+2.
- Backpressure, count=2, out_ready=0 for 5 cycles on the first coordinate:
  - out_valid and the coordinate stay stable through those cycles.
  - No second stk_rd occurs until the handshake.
- count=256, entry i = {i[7:4], i[3:0]}, out_ready=1:
  - 256 coordinates arrive in address order.
  - out_last appears only on (15,15).
  - Exactly one done pulse, and busy lasts 770 cycles.
- Mid-playback events:
  - abort during the second PRESENT of a 4-entry run: next cycle is IDLE, out_valid=0, no done pulse.
  - A start 2 cycles later replays from entry 0.
  - Same run with rst instead of abort: all outputs are 0 the next cycle.
- start re-pulsed in PRESENT, and stack_count changed after acceptance: neither affects the current run's length or output sequence.
